// File: rtl/score_text_gen.sv
// score_text_gen: VGA text overlay for the pong display.
// Status line layout is "SCORE:" + score digits + "BALL:" + ball count (12+NUM_DIGITS cells).
// A blinking "GAME OVER" banner sits BANNER_DY rows below the status line.
// The score is a saturating BCD counter. It is snapshotted on frame_tick so a frame never tears.
// Glyph rows come from an external ASCII ROM addressed by the registered rom_addr.
// Optional feature: define HISCORE_EN to add a high-score register and a "HI:<digits>" line.
module score_text_gen #(
  parameter int unsigned X0           = 240,
  parameter int unsigned Y0           = 40,
  parameter int unsigned SCALE_SHIFT  = 1,
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned BANNER_DY    = 64,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [11:0] TEXT_COLOR   = 12'hF00,
  parameter logic [11:0] OVER_COLOR   = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        score_inc,
  input  logic        score_clr,
  input  logic [1:0]  balls,
  input  logic        game_over,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        text_on,
  output logic [11:0] text_rgb,
  output logic        score_max
);
  localparam int unsigned W  = 8 << SCALE_SHIFT;
  localparam int unsigned H  = 16 << SCALE_SHIFT;
  localparam int unsigned L  = 12 + NUM_DIGITS;
  localparam int unsigned SW = 4 * NUM_DIGITS;
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [SW-1:0] ALL9       = {NUM_DIGITS{4'h9}};
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  localparam logic [10:0] XS    = 11'(X0);
  localparam logic [10:0] XE_ST = 11'(X0 + L * W);
  localparam logic [10:0] XE_BN = 11'(X0 + 9 * W);
  localparam logic [10:0] YS    = 11'(Y0);
  localparam logic [10:0] YE    = 11'(Y0 + H);
  localparam logic [10:0] YB    = 11'(Y0 + BANNER_DY);
  localparam logic [10:0] YBE   = 11'(Y0 + BANNER_DY + H);
`ifdef HISCORE_EN
  localparam logic [10:0] XE_HI = 11'(X0 + (3 + NUM_DIGITS) * W);
  localparam logic [10:0] YHE   = 11'(Y0 + 2 * H);
`endif

  logic [SW-1:0] score_q, score_d, snap_q;
  logic          carry;
  logic [BW-1:0] bcnt_q;
  logic          blink_q;

  // BCD increment with ripple carry; clear wins, all-9s saturates
  always_comb begin
    score_d = score_q;
    carry   = 1'b0;
    if (score_clr) begin
      score_d = '0;
    end else if (score_inc && (score_q != ALL9)) begin
      carry = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (carry) begin
          if (score_q[4*i +: 4] == 4'd9) begin
            score_d[4*i +: 4] = 4'd0;
          end else begin
            score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  assign score_max = (score_q == ALL9);

  // Score counter and per-frame display snapshot (snapshot takes the pre-increment value)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      snap_q  <= '0;
    end else begin
      score_q <= score_d;
      if (frame_tick) snap_q <= score_q;
    end
  end

  // Banner blink: held visible while game_over is low so it shows on the first frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      blink_q <= 1'b1;
    end else if (!game_over) begin
      bcnt_q  <= '0;
      blink_q <= 1'b1;
    end else if (frame_tick) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_q  <= '0;
        blink_q <= ~blink_q;
      end else begin
        bcnt_q <= bcnt_q + BW'(1);
      end
    end
  end

`ifdef HISCORE_EN
  logic [SW-1:0] hisc_q;
  logic          go_q;

  // High score captured on the rising edge of game_over (BCD order matches binary order)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hisc_q <= '0;
      go_q   <= 1'b0;
    end else begin
      go_q <= game_over;
      if (game_over && !go_q && (score_q > hisc_q)) hisc_q <= score_q;
    end
  end
`endif

  logic [10:0] xw, yw, dx, dxs, dy;
  logic [3:0]  row;
  logic [2:0]  bit_d;
  int unsigned ci;
  logic        in_st, in_bn, in_hi;
  logic [6:0]  st_ch, bn_ch, hi_ch;
  logic [10:0] addr_d;

  // Region decode and character selection for the current pixel
  always_comb begin
    xw    = {1'b0, x};
    yw    = {1'b0, y};
    dx    = xw - XS;
    dxs   = dx >> SCALE_SHIFT;
    ci    = 32'(dxs >> 3);
    bit_d = 3'(dxs);
    in_st = (yw >= YS) && (yw < YE) && (xw >= XS) && (xw < XE_ST);
    in_bn = (yw >= YB) && (yw < YBE) && (xw >= XS) && (xw < XE_BN);
`ifdef HISCORE_EN
    in_hi = (yw >= YE) && (yw < YHE) && (xw >= XS) && (xw < XE_HI);
`else
    in_hi = 1'b0;
`endif
    if (in_bn)      dy = yw - YB;
    else if (in_hi) dy = yw - YE;
    else            dy = yw - YS;
    row = 4'(dy >> SCALE_SHIFT);

    st_ch = 7'h00;
    if (ci < 6) begin
      case (ci)
        0:       st_ch = 7'h53;  // S
        1:       st_ch = 7'h43;  // C
        2:       st_ch = 7'h4F;  // O
        3:       st_ch = 7'h52;  // R
        4:       st_ch = 7'h45;  // E
        default: st_ch = 7'h3A;  // :
      endcase
    end else if (ci < 6 + NUM_DIGITS) begin
      st_ch = {3'b011, snap_q[4*(NUM_DIGITS+5-ci) +: 4]};
    end else if (ci < 11 + NUM_DIGITS) begin
      case (ci - 6 - NUM_DIGITS)
        0:       st_ch = 7'h42;  // B
        1:       st_ch = 7'h41;  // A
        2, 3:    st_ch = 7'h4C;  // L
        default: st_ch = 7'h3A;  // :
      endcase
    end else begin
      st_ch = {5'b01100, balls};
    end

    case (ci)
      0:       bn_ch = 7'h47;  // G
      1:       bn_ch = 7'h41;  // A
      2:       bn_ch = 7'h4D;  // M
      3:       bn_ch = 7'h45;  // E
      4:       bn_ch = 7'h20;  // space
      5:       bn_ch = 7'h4F;  // O
      6:       bn_ch = 7'h56;  // V
      7:       bn_ch = 7'h45;  // E
      8:       bn_ch = 7'h52;  // R
      default: bn_ch = 7'h00;
    endcase

    hi_ch = 7'h00;
`ifdef HISCORE_EN
    case (ci)
      0:       hi_ch = 7'h48;  // H
      1:       hi_ch = 7'h49;  // I
      2:       hi_ch = 7'h3A;  // :
      default: if (ci < 3 + NUM_DIGITS) hi_ch = {3'b011, hisc_q[4*(NUM_DIGITS+2-ci) +: 4]};
    endcase
`endif

    addr_d = 11'h000;
    if (in_st)      addr_d = {st_ch, row};
    else if (in_bn) addr_d = {bn_ch, row};
    else if (in_hi) addr_d = {hi_ch, row};
  end

  logic [2:0] bit_q;
  logic       st_q, bn_q, hi_q, lit;

  // Stage 1: ROM address, bit position and qualified region flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      bit_q    <= '0;
      st_q     <= 1'b0;
      bn_q     <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      rom_addr <= addr_d;
      bit_q    <= bit_d;
      st_q     <= in_st & video_on;
      bn_q     <= in_bn & video_on & game_over & blink_q;
      hi_q     <= in_hi & video_on;
    end
  end

  assign lit = (st_q | bn_q | hi_q) & rom_data[3'd7 - bit_q];

  // Stage 2: pick the glyph bit and colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      text_on  <= 1'b0;
      text_rgb <= 12'h000;
    end else begin
      text_on  <= lit;
      text_rgb <= !lit ? 12'h000 : (bn_q ? OVER_COLOR : TEXT_COLOR);
    end
  end

endmodule

// File: tb/tb_score_text_gen.sv
// Self-checking bench for score_text_gen: string-based pixel model plus directed literal checks.
module tb_score_text_gen;
  localparam int X0  = 240;
  localparam int Y0  = 40;
  localparam int SS  = 1;
  localparam int ND  = 2;
  localparam int BDY = 64;
  localparam int BF  = 2;
  localparam int W   = 8 << SS;
  localparam int H   = 16 << SS;
  localparam int MAXSC = (ND == 1) ? 9 : (ND == 2) ? 99 : (ND == 3) ? 999 : 9999;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick, video_on, score_inc, score_clr, game_over;
  logic [9:0]  x, y;
  logic [1:0]  balls;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        text_on, score_max;
  logic [11:0] text_rgb;

  logic [7:0]  rom_tbl [0:2047];
  assign rom_data = rom_tbl[rom_addr];

  always #5 clk = ~clk;

  score_text_gen #(
    .X0(X0), .Y0(Y0), .SCALE_SHIFT(SS), .NUM_DIGITS(ND), .BANNER_DY(BDY),
    .BLINK_FRAMES(BF), .TEXT_COLOR(12'hF00), .OVER_COLOR(12'hFFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .video_on(video_on),
    .x(x), .y(y), .score_inc(score_inc), .score_clr(score_clr), .balls(balls),
    .game_over(game_over), .rom_addr(rom_addr), .rom_data(rom_data),
    .text_on(text_on), .text_rgb(text_rgb), .score_max(score_max)
  );

  int ntot = 0;
  int npass = 0;

  task automatic chk(input string name, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model state: integer score, snapshot, high score, frames since game_over rose
  int m_sc, m_snap, m_hi, m_fs;
  bit m_pgo;
  int e_addr1;
  bit e_on1, e_on2;
  logic [11:0] e_rgb1, e_rgb2;

  function automatic string digs(input int v);
    string r;
    int p;
    r = "";
    p = 1;
    for (int i = 1; i < ND; i++) p = p * 10;
    for (int i = 0; i < ND; i++) begin
      r = {r, $sformatf("%0d", (v / p) % 10)};
      p = p / 10;
    end
    return r;
  endfunction

  // What the screen must show at (px,py) given the model's state
  task automatic pix(input int px, input int py, output int addr, output bit lt,
                     output logic [11:0] rgb);
    string s;
    int top, c, r, col;
    bit drawn, is_bn;
    byte b;
    addr = 0; lt = 1'b0; rgb = 12'h000; s = ""; top = 0; drawn = 1'b0; is_bn = 1'b0;
    if (py >= Y0 && py < Y0 + H) begin
      s = {"SCORE:", digs(m_snap), "BALL:", $sformatf("%0d", balls)};
      top = Y0; drawn = 1'b1;
    end else if (py >= Y0 + BDY && py < Y0 + BDY + H) begin
      s = "GAME OVER";
      top = Y0 + BDY; is_bn = 1'b1;
      drawn = game_over && (((m_fs / BF) % 2) == 0);
    end
`ifdef HISCORE_EN
    else if (py >= Y0 + H && py < Y0 + 2 * H) begin
      s = {"HI:", digs(m_hi)};
      top = Y0 + H; drawn = 1'b1;
    end
`endif
    if (s.len() > 0 && px >= X0 && px < X0 + s.len() * W) begin
      b    = s[(px - X0) / W];
      c    = int'(b);
      r    = ((py - top) / (1 << SS)) % 16;
      col  = ((px - X0) / (1 << SS)) % 8;
      addr = c * 16 + r;
      lt   = drawn && video_on && rom_tbl[addr][7 - col];
      if (lt) rgb = is_bn ? 12'hFFF : 12'hF00;
    end
  endtask

  // Reference model, advanced on every active edge (or reset)
  initial begin
    int a;
    bit l;
    logic [11:0] c;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_sc = 0; m_snap = 0; m_hi = 0; m_fs = 0; m_pgo = 1'b0;
        e_addr1 = 0; e_on1 = 1'b0; e_on2 = 1'b0; e_rgb1 = 12'h000; e_rgb2 = 12'h000;
      end else begin
        e_on2 = e_on1; e_rgb2 = e_rgb1;
        pix(int'(x), int'(y), a, l, c);
        e_addr1 = a; e_on1 = l; e_rgb1 = c;
        if (frame_tick) m_snap = m_sc;
        if (game_over && !m_pgo && m_sc > m_hi) m_hi = m_sc;
        m_pgo = game_over;
        if (!game_over) m_fs = 0;
        else if (frame_tick) m_fs++;
        if (score_clr) m_sc = 0;
        else if (score_inc && m_sc < MAXSC) m_sc++;
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("cyc_rom_addr", int'(rom_addr), e_addr1);
        chk("cyc_text_on", int'(text_on), int'(e_on2));
        chk("cyc_text_rgb", int'(text_rgb), int'(e_rgb2));
        chk("cyc_score_max", int'(score_max), int'(m_sc == MAXSC));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input int n);
    cyc(); score_inc = 1'b1;
    repeat (n - 1) cyc();
    cyc(); score_inc = 1'b0;
  endtask

  task automatic pulse_clr();
    cyc(); score_clr = 1'b1;
    cyc(); score_clr = 1'b0;
  endtask

  task automatic pulse_tick();
    cyc(); frame_tick = 1'b1;
    cyc(); frame_tick = 1'b0;
  endtask

  // Present (px,py) and check rom_addr one edge later
  task automatic addr_at(input string name, input int px, input int py, input int exp);
    x = 10'(px); y = 10'(py);
    cyc();
    @(negedge clk);
    chk(name, int'(rom_addr), exp);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom_tbl[i] = 8'($urandom);
    rom_tbl[11'h530] = 8'h7C;  // 'S' row 0
    rom_tbl[11'h470] = 8'hFF;  // 'G' row 0
    rst_n = 1'b0; frame_tick = 1'b0; video_on = 1'b0; score_inc = 1'b0; score_clr = 1'b0;
    game_over = 1'b0; balls = 2'd3; x = 10'd0; y = 10'd0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // First glyph of the status line
    video_on = 1'b1; x = 10'd240; y = 10'd40;
    cyc(); @(negedge clk); chk("S_rom_addr", int'(rom_addr), 11'h530);
    cyc(); @(negedge clk); chk("S_bit7_off", int'(text_on), 0);
    x = 10'd242;
    cyc(); cyc(); @(negedge clk);
    chk("S_bit6_on", int'(text_on), 1);
    chk("S_rgb", int'(text_rgb), 12'hF00);

    // Saturation and clear priority
    pulse_clr(); pulse_inc(99);
    cyc(); @(negedge clk); chk("max_at_99", int'(score_max), 1);
    pulse_inc(1);
    cyc(); @(negedge clk); chk("max_held", int'(score_max), 1);
    pulse_tick();
    addr_at("sat_tens", 336, 40, 11'h390);
    addr_at("sat_ones", 352, 40, 11'h390);
    cyc(); score_inc = 1'b1; score_clr = 1'b1;
    cyc(); score_inc = 1'b0; score_clr = 1'b0;
    @(negedge clk); chk("clr_max", int'(score_max), 0);

    // Snapshot: increment coincident with frame_tick shows next frame
    pulse_clr(); pulse_inc(9);
    cyc(); score_inc = 1'b1; frame_tick = 1'b1;
    cyc(); score_inc = 1'b0; frame_tick = 1'b0;
    addr_at("snap09_tens", 336, 40, 11'h300);
    addr_at("snap09_ones", 352, 40, 11'h390);
    pulse_tick();
    addr_at("snap10_tens", 336, 40, 11'h310);
    addr_at("snap10_ones", 352, 40, 11'h300);

    // Banner blink, BLINK_FRAMES=2: lit 0-1, dark 2-3, lit 4-5
    x = 10'd240; y = 10'd104;
    cyc(); game_over = 1'b1;
    for (int f = 0; f < 6; f++) begin
      cyc(); cyc(); @(negedge clk);
      chk($sformatf("blink_on_f%0d", f), int'(text_on), int'(((f / 2) % 2) == 0));
      chk($sformatf("blink_rgb_f%0d", f), int'(text_rgb), (((f / 2) % 2) == 0) ? 12'hFFF : 0);
      pulse_tick();
    end
    cyc(); game_over = 1'b0;
    for (int f = 0; f < 2; f++) begin
      cyc(); cyc(); @(negedge clk);
      chk($sformatf("banner_off_f%0d", f), int'(text_on), 0);
      pulse_tick();
    end

`ifdef HISCORE_EN
    pulse_clr(); pulse_inc(42);
    cyc(); game_over = 1'b1;
    cyc(); game_over = 1'b0;
    addr_at("hi42_tens", 288, 72, 11'h340);
    addr_at("hi42_ones", 304, 72, 11'h320);
    pulse_clr(); pulse_inc(10);
    cyc(); game_over = 1'b1;
    cyc(); game_over = 1'b0;
    addr_at("hi_kept_tens", 288, 72, 11'h340);
    addr_at("hi_kept_ones", 304, 72, 11'h320);
`else
    addr_at("no_hi_line", 288, 72, 11'h000);
    cyc(); @(negedge clk); chk("no_hi_dark", int'(text_on), 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      x          = 10'(X0 - 16 + int'($urandom_range(0, 18 * W)));
      y          = 10'(Y0 - 8 + int'($urandom_range(0, BDY + H + 16)));
      video_on   = ($urandom_range(0, 9) != 0);
      score_inc  = ($urandom_range(0, 2) == 0);
      score_clr  = ($urandom_range(0, 599) == 0);
      frame_tick = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) game_over = ~game_over;
      if ($urandom_range(0, 49) == 0) balls = 2'($urandom_range(0, 3));
    end
    cyc();
    score_inc = 1'b0; score_clr = 1'b0; frame_tick = 1'b0; game_over = 1'b0; video_on = 1'b1;

    // Reset mid-frame with score 37
    pulse_clr(); pulse_inc(37); pulse_tick();
    x = 10'd242; y = 10'd40;
    cyc(); cyc(); @(negedge clk); chk("pre_reset_on", int'(text_on), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_text_on", int'(text_on), 0);
    chk("rst_text_rgb", int'(text_rgb), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_score_max", int'(score_max), 0);
    cyc(); cyc(); rst_n = 1'b1;
    pulse_tick();
    addr_at("post_rst_tens", 336, 40, 11'h300);
    addr_at("post_rst_ones", 352, 40, 11'h300);

    cyc();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
